hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 92 +++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Issue-stage hazard controller: RAW/WAW interlock against a per-register
// late-write scoreboard, load capacity limit and multi-cycle multiply occupancy.
module hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned MAX_LOADS  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_issue_valid,
    input  logic        i_rm_used,
    input  logic        i_rn_used,
    input  logic        i_rs_used,
    input  logic [3:0]  i_rm_code,
    input  logic [3:0]  i_rn_code,
    input  logic [3:0]  i_rs_code,
    input  logic        i_rd_en,
    input  logic [3:0]  i_rd_code,
    input  logic        i_rd_late,
    input  logic        i_mul,
    input  logic        i_mem_done,
    input  logic [3:0]  i_mem_rd_code,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_issue,
    output logic        o_ex_busy,
    output logic [15:0] o_pending,
    output logic [3:0]  o_load_cnt
);

    localparam int unsigned NREG = 16;
    localparam int unsigned CW   = 4;

    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] hot;
    logic [NREG-1:0] pending_nxt;
    logic [CW-1:0]   mul_cnt;
    logic            raw;
    logic            waw;
    logic            full;
    logic            mem_ret;
    logic            load_set;

    // A register returning this cycle is forwarded from WB, so it is not hot.
    always_comb begin
        clr_vec = i_mem_done ? (NREG'(1) << i_mem_rd_code) : '0;
        hot     = o_pending & ~clr_vec;
        raw     = (i_rm_used & hot[i_rm_code]) |
                  (i_rn_used & hot[i_rn_code]) |
                  (i_rs_used & hot[i_rs_code]);
        waw     = i_rd_en & hot[i_rd_code];
        full    = i_rd_en & i_rd_late & (o_load_cnt == CW'(MAX_LOADS)) & ~i_mem_done;
    end

    assign o_ex_busy = (mul_cnt != '0);
    assign o_stall   = i_rst_n & i_issue_valid & ~i_flush & (raw | waw | full | o_ex_busy);
    assign o_issue   = i_rst_n & i_issue_valid & ~i_flush & ~o_stall;

    assign mem_ret  = i_mem_done & (o_load_cnt != '0);
    assign load_set = o_issue & i_rd_en & i_rd_late;

    // Clear applied first so a same-register set in the same cycle wins.
    always_comb begin
        pending_nxt = o_pending;
        if (mem_ret) begin
            pending_nxt[i_mem_rd_code] = 1'b0;
        end
        if (load_set) begin
            pending_nxt[i_rd_code] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pending  <= '0;
            o_load_cnt <= '0;
            mul_cnt    <= '0;
        end else begin
            o_pending <= pending_nxt;
            case ({load_set, mem_ret})
                2'b10:   o_load_cnt <= o_load_cnt + CW'(1);
                2'b01:   o_load_cnt <= o_load_cnt - CW'(1);
                default: o_load_cnt <= o_load_cnt;
            endcase
            if (o_issue && i_mul) begin
                mul_cnt <= CW'(MUL_CYCLES - 1);
            end else if (mul_cnt != '0) begin
                mul_cnt <= mul_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a scoreboard model
// built from per-register flags, an outstanding-load count and a multiply countdown.
module tb_hazard_ctrl;

    localparam int MUL_CYCLES = 4;
    localparam int MAX_LOADS  = 2;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic        rm_used, rn_used, rs_used;
    logic [3:0]  rm_code, rn_code, rs_code;
    logic        rd_en;
    logic [3:0]  rd_code;
    logic        rd_late;
    logic        mul;
    logic        mem_done;
    logic [3:0]  mem_rd_code;
    logic        flush;
    logic        o_stall, o_issue, o_ex_busy;
    logic [15:0] o_pending;
    logic [3:0]  o_load_cnt;

    int total = 0;
    int bad   = 0;

    // Reference state
    bit m_pend[16];
    int m_cnt;
    int m_mul_left;

    hazard_ctrl #(.MUL_CYCLES(MUL_CYCLES), .MAX_LOADS(MAX_LOADS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_issue_valid(issue_valid),
        .i_rm_used(rm_used), .i_rn_used(rn_used), .i_rs_used(rs_used),
        .i_rm_code(rm_code), .i_rn_code(rn_code), .i_rs_code(rs_code),
        .i_rd_en(rd_en), .i_rd_code(rd_code), .i_rd_late(rd_late),
        .i_mul(mul), .i_mem_done(mem_done), .i_mem_rd_code(mem_rd_code),
        .i_flush(flush), .o_stall(o_stall), .o_issue(o_issue),
        .o_ex_busy(o_ex_busy), .o_pending(o_pending), .o_load_cnt(o_load_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        issue_valid = 0; rm_used = 0; rn_used = 0; rs_used = 0;
        rm_code = 0; rn_code = 0; rs_code = 0;
        rd_en = 0; rd_code = 0; rd_late = 0; mul = 0;
        mem_done = 0; mem_rd_code = 0; flush = 0;
    endtask

    task automatic m_reset();
        foreach (m_pend[r]) m_pend[r] = 0;
        m_cnt = 0;
        m_mul_left = 0;
    endtask

    function automatic logic [15:0] m_vec();
        logic [15:0] v = '0;
        for (int r = 0; r < 16; r++) if (m_pend[r]) v[r] = 1'b1;
        return v;
    endfunction

    function automatic bit m_hot(input int r);
        return m_pend[r] && !(mem_done && int'(mem_rd_code) == r);
    endfunction

    // Check one cycle's combinational outputs and state, then clock and advance the model.
    task automatic step(input string tag);
        bit raw, waw, full, st, is;
        #1;
        raw  = (rm_used && m_hot(int'(rm_code))) || (rn_used && m_hot(int'(rn_code))) ||
               (rs_used && m_hot(int'(rs_code)));
        waw  = rd_en && m_hot(int'(rd_code));
        full = rd_en && rd_late && (m_cnt == MAX_LOADS) && !mem_done;
        st   = issue_valid && !flush && (raw || waw || full || m_mul_left > 0);
        is   = issue_valid && !flush && !st;
        chk({tag, ".stall"}, 32'(o_stall), 32'(st));
        chk({tag, ".issue"}, 32'(o_issue), 32'(is));
        chk({tag, ".busy"}, 32'(o_ex_busy), 32'(m_mul_left > 0));
        chk({tag, ".pending"}, 32'(o_pending), 32'(m_vec()));
        chk({tag, ".cnt"}, 32'(o_load_cnt), 32'(m_cnt));
        @(posedge clk);
        #1;
        if (mem_done && m_cnt > 0) begin
            m_pend[mem_rd_code] = 0;
            m_cnt--;
        end
        if (is && rd_en && rd_late) begin
            m_pend[rd_code] = 1;
            m_cnt++;
        end
        if (is && mul) m_mul_left = MUL_CYCLES - 1;
        else if (m_mul_left > 0) m_mul_left--;
    endtask

    task automatic expect_now(input string tag, input logic st, input logic is);
        #1;
        chk({tag, ".stall_k"}, 32'(o_stall), 32'(st));
        chk({tag, ".issue_k"}, 32'(o_issue), 32'(is));
    endtask

    task automatic load(input logic [3:0] r);
        clr_in(); issue_valid = 1; rd_en = 1; rd_late = 1; rd_code = r;
    endtask

    task automatic ret(input logic [3:0] r);
        clr_in(); mem_done = 1; mem_rd_code = r;
    endtask

    initial begin
        int q[$];
        clr_in();
        m_reset();
        rst_n = 0;
        issue_valid = 1;
        #3;
        chk("rst.issue", 32'(o_issue), 0);
        chk("rst.stall", 32'(o_stall), 0);
        chk("rst.pending", 32'(o_pending), 0);
        chk("rst.cnt", 32'(o_load_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1;
        clr_in();

        // Load-use
        load(4'd3); step("lu_ldr");
        clr_in(); issue_valid = 1; rm_used = 1; rm_code = 3; rd_en = 1; rd_code = 8;
        expect_now("lu_wait", 1, 0);
        step("lu_wait1"); step("lu_wait2");
        mem_done = 1; mem_rd_code = 3;
        expect_now("lu_ret", 0, 1);
        step("lu_ret");

        // Capacity
        load(4'd1); step("cap_l1");
        load(4'd2); step("cap_l2");
        load(4'd4); expect_now("cap_full", 1, 0);
        chk("cap_cnt2", 32'(o_load_cnt), 2);
        step("cap_full");
        mem_done = 1; mem_rd_code = 1;
        expect_now("cap_ret", 0, 1);
        step("cap_ret");
        chk("cap_cnt_kept", 32'(o_load_cnt), 2);
        ret(4'd2); step("cap_d2");
        ret(4'd4); step("cap_d4");
        ret(4'd9); step("cap_spurious");
        chk("cap_cnt0", 32'(o_load_cnt), 0);

        // Multiply occupancy
        clr_in(); issue_valid = 1; mul = 1; rd_en = 1; rd_code = 6;
        step("mul_issue");
        clr_in(); issue_valid = 1; rd_en = 1; rd_code = 10;
        for (int c = 1; c <= 3; c++) begin
            expect_now($sformatf("mul_c%0d", c), 1, 0);
            chk($sformatf("mul_busy%0d", c), 32'(o_ex_busy), 1);
            step($sformatf("mul_c%0d", c));
        end
        expect_now("mul_c4", 0, 1);
        step("mul_c4");

        // Set/clear collision on r5
        load(4'd5); step("col_l5");
        load(4'd5); mem_done = 1; mem_rd_code = 5;
        expect_now("col_both", 0, 1);
        step("col_both");
        chk("col_pend5", 32'(o_pending[5]), 1);
        chk("col_cnt", 32'(o_load_cnt), 1);
        ret(4'd5); step("col_drain");

        // WAW then flush
        load(4'd7); step("waw_l7");
        load(4'd7); expect_now("waw_stall", 1, 0); step("waw_stall");
        flush = 1; expect_now("waw_flush", 0, 0); step("waw_flush");
        chk("waw_pend7", 32'(o_pending[7]), 1);
        ret(4'd7); step("waw_drain");

        // Async reset mid-multiply with loads outstanding
        load(4'd1); step("ar_l1");
        load(4'd2); step("ar_l2");
        clr_in(); issue_valid = 1; mul = 1; step("ar_mul");
        clr_in(); issue_valid = 1;
        #1;
        chk("ar_pre_pend", 32'(o_pending), 32'h6);
        chk("ar_pre_busy", 32'(o_ex_busy), 1);
        rst_n = 0;
        #1;
        chk("ar.pending", 32'(o_pending), 0);
        chk("ar.cnt", 32'(o_load_cnt), 0);
        chk("ar.busy", 32'(o_ex_busy), 0);
        chk("ar.stall", 32'(o_stall), 0);
        chk("ar.issue", 32'(o_issue), 0);
        m_reset();
        @(posedge clk); #1;
        chk("ar.hold_issue", 32'(o_issue), 0);
        rst_n = 1;
        clr_in(); issue_valid = 1; rm_used = 1; rm_code = 1; rn_used = 1; rn_code = 2;
        expect_now("ar_free", 0, 1);
        step("ar_free");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            clr_in();
            issue_valid = ($urandom_range(0, 3) != 0);
            rm_used = 1'($urandom); rn_used = 1'($urandom); rs_used = 1'($urandom);
            rm_code = 4'($urandom); rn_code = 4'($urandom); rs_code = 4'($urandom);
            rd_en = 1'($urandom); rd_code = 4'($urandom); rd_late = 1'($urandom);
            mul = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            q.delete();
            for (int r = 0; r < 16; r++) if (m_pend[r]) q.push_back(r);
            if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                mem_done = 1;
                mem_rd_code = 4'(q[$urandom_range(0, q.size() - 1)]);
            end else if ($urandom_range(0, 19) == 0) begin
                mem_done = 1;
                mem_rd_code = 4'($urandom);
            end
            step($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
